// File: rtl/seq_mult_core_if.sv
// Operand/result bundle for seq_mult_core: start strobe and operands in, product/done/busy out.
interface seq_mult_core_if #(
    parameter int unsigned WIDTH = 4
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2*WIDTH-1:0]   product;
    logic                 done;
    logic                 busy;

    modport master (output start, a, b, input product, done, busy);
    modport slave  (input start, a, b, output product, done, busy);
endinterface

// File: rtl/seq_mult_core.sv
// Sequential shift-and-add unsigned multiplier; product held between operations.
// Optional SEQ_MULT_START_SYNC_EN: synchronize start and use its rising edge as the request.
module seq_mult_core #(
    parameter int unsigned WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    seq_mult_core_if.slave  bus
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            w_start_eff;
    logic            w_load;
    logic            w_calc;
    logic            w_finish;
    logic            w_busy_nxt;

    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    r_product;
    logic             r_done;
    logic             r_busy;

`ifdef SEQ_MULT_START_SYNC_EN
    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Two-flop synchronizer plus one history flop for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= bus.start;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_start_eff = r_s2 & ~r_s3;
`else
    assign w_start_eff = bus.start;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_start_eff)         w_next = S_CALC;
            S_CALC: if (r_count == LAST_CNT) w_next = S_DONE;
            S_DONE:                          w_next = S_IDLE;
            default:                         w_next = S_IDLE;
        endcase
    end

    // Per-state datapath controls
    always_comb begin
        w_load     = 1'b0;
        w_calc     = 1'b0;
        w_finish   = 1'b0;
        case (r_state)
            S_IDLE:  w_load   = w_start_eff;
            S_CALC:  w_calc   = 1'b1;
            S_DONE:  w_finish = 1'b1;
            default: ;
        endcase
        w_busy_nxt = (w_next != S_IDLE);
    end

    // Datapath and registered outputs; product only moves on the DONE edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_count   <= '0;
            r_product <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_busy <= w_busy_nxt;
            if (w_load) begin
                r_mcand  <= PW'(bus.a);
                r_mplier <= bus.b;
                r_acc    <= '0;
                r_count  <= '0;
            end
            if (w_calc) begin
                r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_count  <= r_count + CW'(1);
            end
            if (w_finish) begin
                r_product <= r_acc;
                r_done    <= 1'b1;
            end
        end
    end

    assign bus.product = r_product;
    assign bus.done    = r_done;
    assign bus.busy    = r_busy;

endmodule

// File: tb/tb_seq_mult_core.sv
// Scoreboard bench for seq_mult_core: directed scenarios plus random start/operand/reset traffic.
module tb_seq_mult_core;
    localparam int unsigned W  = 4;
    localparam int unsigned PW = 2 * W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_mult_core_if #(.WIDTH(W)) bus();

    seq_mult_core #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [PW-1:0] p;
        int            c;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_done = 0;
    bit   mon_en = 1'b0;

    // Reference model: a request starts a timer of W+1 edges; product = a*b when it expires
    int            m_left = 0;
    logic [PW-1:0] m_prod = '0;
    logic [PW-1:0] m_pend = '0;
    logic          m_done = 1'b0;
    logic          h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        logic eff;
        cyc++;
`ifdef SEQ_MULT_START_SYNC_EN
        eff = h2 & ~h3;
        h3 = h2;
        h2 = h1;
        h1 = bus.start;
`else
        eff = bus.start;
`endif
        m_done = 1'b0;
        if (rst) begin
            m_left = 0;
            m_prod = '0;
            h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
            sb.delete();
        end else if (m_left == 0) begin
            if (eff) begin
                m_pend = PW'(bus.a) * PW'(bus.b);
                m_left = W + 1;
                sb.push_back('{p: m_pend, c: cyc + W + 1});
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_prod = m_pend;
                m_done = 1'b1;
            end
        end
    end

    // Monitor: per-cycle output checks and scoreboard pop on every done pulse
    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", 32'(bus.busy), 32'(m_left != 0));
            check("product_hold", 32'(bus.product), 32'(m_prod));
            check("done", 32'(bus.done), 32'(m_done));
            if (bus.done === 1'b1) begin
                exp_t e;
                n_done++;
                if (sb.size() == 0) begin
                    check("done_without_request", 32'(1), 32'(0));
                end else begin
                    e = sb.pop_front();
                    check("sb_product", 32'(bus.product), 32'(e.p));
                    check("sb_latency", 32'(cyc), 32'(e.c));
                end
            end
        end
    end

    task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib);
        bus.a = ia;
        bus.b = ib;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("done_timeout", 32'(seen), 32'(1));
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            if (bus.busy === 1'b0) begin
                idle = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("idle_timeout", 32'(idle), 32'(1));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int  d0;
        bit  went_busy;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        @(negedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_product", 32'(bus.product), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        op(4'd3, 4'd5);
`ifndef SEQ_MULT_START_SYNC_EN
        check("busy_after_accept", 32'(bus.busy), 32'h1);
`endif
        wait_done();
        check("prod_3x5", 32'(bus.product), 32'h0F);
        @(negedge clk);
        check("busy_low_after_done", 32'(bus.busy), 32'h0);
        wait_idle();

        op(4'd15, 4'd15);
        wait_done();
        check("prod_15x15", 32'(bus.product), 32'hE1);
        wait_idle();
        op(4'd0, 4'd9);
        wait_done();
        check("prod_0x9", 32'(bus.product), 32'h00);
        wait_idle();

        // Operand change and re-start while busy are both ignored
        op(4'd15, 4'd15);
        wait_done();
        wait_idle();
        d0 = n_done;
        op(4'd2, 4'd3);
        repeat (3) @(negedge clk);
        bus.a = 4'd7;
        bus.b = 4'd7;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("hold_during_calc", 32'(bus.product), 32'hE1);
        wait_done();
        check("prod_2x3", 32'(bus.product), 32'h06);
        wait_idle();
        check("single_done", 32'(n_done - d0), 32'h1);

        // Reset on the second CALC edge abandons the operation
        op(4'd15, 4'd15);
        wait_done();
        wait_idle();
        op(4'd4, 4'd4);
        went_busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.busy === 1'b1) begin
                went_busy = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("went_busy", 32'(went_busy), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_product", 32'(bus.product), 32'h0);
        check("midrst_busy", 32'(bus.busy), 32'h0);
        check("midrst_done", 32'(bus.done), 32'h0);
        d0 = n_done;
        repeat (10) @(negedge clk);
        check("no_done_after_rst", 32'(n_done - d0), 32'h0);

        // Held start
        bus.a = 4'd2;
        bus.b = 4'd7;
        d0 = n_done;
        bus.start = 1'b1;
        repeat (20) @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
`ifdef SEQ_MULT_START_SYNC_EN
        check("held_done_count", 32'(n_done - d0), 32'h1);
`else
        check("held_done_count", 32'(n_done - d0), 32'h4);
`endif
        check("prod_2x7", 32'(bus.product), 32'h0E);

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            bus.start = ($urandom_range(0, 3) == 0);
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        bus.start = 1'b0;
        wait_idle();
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
